// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data cache memory arbiter.
// The address window is also used by the data-memory stage error check.
package mem_arbiter_pkg;

    // Legal memory window: [DMEM_ADDR_LO, DMEM_ADDR_HI)
    localparam logic [31:0] DMEM_ADDR_LO = 32'h8000_0000;
    localparam logic [31:0] DMEM_ADDR_HI = 32'h8004_0000;

    // Width of the ISSUE+WAIT timeout counter
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } ArbState;

    typedef struct packed {
        logic         we;
        logic [31:0]  addr;
        logic [127:0] wdata;
        logic [15:0]  wmask;
    } MemReq;

    // True when an address is misaligned or outside [lo, hi)
    function automatic logic addr_bad(input logic [31:0] addr,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (addr[1:0] != 2'b00) || (addr < lo) || (addr >= hi);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick. Purely combinational; the caller owns the
// "last granted" history and updates it only when a grant is accepted.
module rr_arbiter2 (
    input  logic [1:0] valid_i,
    input  logic       last_i,   // index of the requester granted last
    output logic [1:0] grant_o   // one-hot, zero when nobody requests
);

    // Single requester wins outright; on a tie the one not granted last wins
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant_o = 2'b00;
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one downstream memory port between the instruction cache
// (requester 0) and the data cache (requester 1). Bad addresses and
// downstream timeouts are answered locally with an error response.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic [31:0] ADDR_LO = DMEM_ADDR_LO,
    parameter logic [31:0] ADDR_HI = DMEM_ADDR_HI,
    parameter int unsigned TIMEOUT = 255          // 1..255
) (
    input  logic             clk,
    input  logic             rst,                 // synchronous, active low

    // Requester side (index 0 = icache, 1 = dcache)
    input  logic [1:0]        m_valid,
    input  logic [1:0]        m_we,
    input  logic [1:0][31:0]  m_addr,
    input  logic [1:0][127:0] m_wdata,
    input  logic [1:0][15:0]  m_wmask,
    output logic [1:0]        m_ready,
    output logic [1:0]        m_rvalid,
    output logic [127:0]      m_rdata,
    output logic              m_err,

    // Downstream memory port
    output logic              s_valid,
    output logic              s_we,
    output logic [31:0]       s_addr,
    output logic [127:0]      s_wdata,
    output logic [15:0]       s_wmask,
    input  logic              s_ready,
    input  logic              s_rvalid,
    input  logic [127:0]      s_rdata
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    ArbState          state_q, state_d;
    logic             last_q, last_d;         // requester granted last
    logic             gnt_idx_q, gnt_idx_d;   // owner of the current transaction
    logic             err_q, err_d;           // current transaction will answer with error
    MemReq            req_q, req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [127:0]     rdata_q, rdata_d;
    logic [1:0]       rvalid_q, rvalid_d;
    logic             merr_q, merr_d;

    logic [1:0]       grant;
    logic             accept;
    logic             acc_idx;
    logic             acc_err;
    logic             timed_out;
    MemReq            sel_req;

    rr_arbiter2 u_rr (
        .valid_i (m_valid),
        .last_i  (last_q),
        .grant_o (grant)
    );

    assign accept    = |m_ready;
    assign acc_idx   = grant[1];
    assign sel_req   = '{we:    m_we[acc_idx],
                         addr:  m_addr[acc_idx],
                         wdata: m_wdata[acc_idx],
                         wmask: m_wmask[acc_idx]};
    assign acc_err   = addr_bad(sel_req.addr, ADDR_LO, ADDR_HI);
    // ">=" also covers WAIT entered by a handshake that beat the timeout
    assign timed_out = (cnt_q >= TIMEOUT_CNT);

    // FSM state register
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a downstream handshake beats a same-cycle timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = acc_err ? RESP : ISSUE;
            end
            ISSUE: begin
                if (s_ready)        state_d = WAIT;
                else if (timed_out) state_d = RESP;
            end
            WAIT: begin
                if (s_rvalid)       state_d = RESP;
                else if (timed_out) state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: accept strobe only in IDLE out of reset, request valid in ISSUE
    always_comb begin
        m_ready = 2'b00;
        s_valid = 1'b0;
        if (state_q == IDLE && rst) m_ready = grant;
        if (state_q == ISSUE)       s_valid = 1'b1;
    end

    // Transaction datapath: latch on accept, count ISSUE+WAIT, capture response
    always_comb begin
        last_d    = last_q;
        gnt_idx_d = gnt_idx_q;
        err_d     = err_q;
        req_d     = req_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    last_d    = acc_idx;
                    gnt_idx_d = acc_idx;
                    err_d     = acc_err;
                    req_d     = sel_req;
                    cnt_d     = '0;
                    if (acc_err) rdata_d = '0;
                end
            end
            ISSUE: begin
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                if (!s_ready && timed_out) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            WAIT: begin
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                if (s_rvalid) begin
                    err_d   = 1'b0;
                    rdata_d = s_rdata;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Response strobe is registered: it fires in the single RESP cycle
    always_comb begin
        rvalid_d = 2'b00;
        merr_d   = 1'b0;
        if (state_d == RESP) begin
            rvalid_d = gnt_idx_d ? 2'b10 : 2'b01;
            merr_d   = err_d;
        end
    end

    // Datapath registers; reset abandons any transaction without a response
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q    <= 1'b1;
            gnt_idx_q <= 1'b0;
            err_q     <= 1'b0;
            req_q     <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 2'b00;
            merr_q    <= 1'b0;
        end else begin
            last_q    <= last_d;
            gnt_idx_q <= gnt_idx_d;
            err_q     <= err_d;
            req_q     <= req_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            merr_q    <= merr_d;
        end
    end

    assign s_we     = req_q.we;
    assign s_addr   = req_q.addr;
    assign s_wdata  = req_q.wdata;
    assign s_wmask  = req_q.wmask;
    assign m_rvalid = rvalid_q;
    assign m_rdata  = rdata_q;
    assign m_err    = merr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Stimulus pushes expected responses into a
// scoreboard queue; a monitor pops and compares whenever m_rvalid fires.
module tb_mem_arbiter;

    localparam int unsigned TO = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]        m_valid = '0;
    logic [1:0]        m_we = '0;
    logic [1:0][31:0]  m_addr = '0;
    logic [1:0][127:0] m_wdata = '0;
    logic [1:0][15:0]  m_wmask = '0;
    logic [1:0]        m_ready;
    logic [1:0]        m_rvalid;
    logic [127:0]      m_rdata;
    logic              m_err;
    logic              s_valid;
    logic              s_we;
    logic [31:0]       s_addr;
    logic [127:0]      s_wdata;
    logic [15:0]       s_wmask;
    logic              s_ready = 1'b0;
    logic              s_rvalid = 1'b0;
    logic [127:0]      s_rdata = '0;

    mem_arbiter #(
        .ADDR_LO (32'h8000_0000),
        .ADDR_HI (32'h8004_0000),
        .TIMEOUT (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m_valid  (m_valid),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_wmask  (m_wmask),
        .m_ready  (m_ready),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata),
        .m_err    (m_err),
        .s_valid  (s_valid),
        .s_we     (s_we),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wmask  (s_wmask),
        .s_ready  (s_ready),
        .s_rvalid (s_rvalid),
        .s_rdata  (s_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        logic [1:0]   rv;
        logic [127:0] data;
        logic         err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [1:0] rv, input logic [127:0] d, input logic e);
        exp_t x;
        x.cyc = c; x.rv = rv; x.data = d; x.err = e;
        sb_q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int r, input logic we, input logic [31:0] addr,
                             input logic [127:0] wd, input logic [15:0] wm);
        m_valid[r] = 1'b1;
        m_we[r]    = we;
        m_addr[r]  = addr;
        m_wdata[r] = wd;
        m_wmask[r] = wm;
    endtask

    task automatic expect_accept(input string name, input logic [1:0] g, output int t);
        @(negedge clk);
        check(name, m_ready, g);
        t = cyc;
    endtask

    // From the accept cycle: s_ready at T+1, s_rvalid at T+2; ends in T+3
    task automatic serve(input logic [31:0] exp_addr, input logic [127:0] d, input logic [1:0] keep);
        tick();
        m_valid = m_valid & keep;
        s_ready = 1'b1;
        @(negedge clk);
        check("issue_s_valid", s_valid, 1'b1);
        check("issue_s_addr", s_addr, exp_addr);
        check("busy_m_ready", m_ready, 2'b00);
        tick();
        s_ready  = 1'b0;
        s_rvalid = 1'b1;
        s_rdata  = d;
        tick();
        s_rvalid = 1'b0;
        s_rdata  = '0;
    endtask

    task automatic read_ok(input int r, input logic [31:0] addr, input logic [127:0] d);
        int t;
        logic [1:0] g;
        g = (r == 1) ? 2'b10 : 2'b01;
        m_valid = '0;
        drive_req(r, 1'b0, addr, '0, '0);
        expect_accept("rd_grant", g, t);
        push(t + 3, g, d, 1'b0);
        serve(addr, d, 2'b00);
        tick();
    endtask

    // Local error: response one cycle after accept, next accept possible at T+2
    task automatic local_err(input int r, input logic [31:0] addr);
        int t;
        logic [1:0] g;
        g = (r == 1) ? 2'b10 : 2'b01;
        m_valid = '0;
        drive_req(r, 1'b0, addr, '0, '0);
        expect_accept("err_grant", g, t);
        push(t + 1, g, '0, 1'b1);
        tick();
        m_valid = '0;
        @(negedge clk);
        check("err_no_s_valid", s_valid, 1'b0);
        tick();
    endtask

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (m_rvalid != 2'b00) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_rvalid", m_rvalid, 2'b00);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("rsp_cycle", 128'(cyc), 128'(mon_e.cyc));
                    check("rsp_rvalid", m_rvalid, mon_e.rv);
                    check("rsp_rdata", m_rdata, mon_e.data);
                    check("rsp_err", m_err, mon_e.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int t2;
        logic [1:0] g;
        logic [127:0] d;

        // Reset with both requesters asking: m_ready must stay low
        rst = 1'b0;
        drive_req(0, 1'b0, 32'h8000_0100, '0, '0);
        drive_req(1, 1'b0, 32'h8000_0200, '0, '0);
        repeat (3) tick();
        @(negedge clk);
        check("rst_m_ready", m_ready, 2'b00);
        check("rst_s_valid", s_valid, 1'b0);
        check("rst_m_rvalid", m_rvalid, 2'b00);
        check("rst_m_err", m_err, 1'b0);
        check("rst_m_rdata", m_rdata, '0);
        tick();
        rst = 1'b1;

        // Both valid continuously: grants 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            g = (i % 2 == 0) ? 2'b01 : 2'b10;
            d = {4{32'hC0DE_0000 + 32'(i)}};
            expect_accept("rr_grant", g, t);
            push(t + 3, g, d, 1'b0);
            serve((g == 2'b01) ? 32'h8000_0100 : 32'h8000_0200, d, 2'b11);
            tick();
        end
        m_valid = '0;

        // Nominal single read and window boundaries
        read_ok(0, 32'h8000_0010, {16{8'hA5}});
        read_ok(0, 32'h8000_0000, {4{32'h1111_2222}});
        read_ok(1, 32'h8003_FFFC, {4{32'h3333_4444}});

        // Locally answered errors, back to back
        local_err(1, 32'h7FFF_FFF0);
        local_err(1, 32'h8000_0002);
        local_err(1, 32'h8004_0000);
        local_err(0, 32'h8000_0011);

        // Timeout in ISSUE: s_valid high TO+1 cycles, response at T+TO+2
        m_valid = '0;
        drive_req(0, 1'b0, 32'h8000_0020, '0, '0);
        expect_accept("to_grant", 2'b01, t);
        push(t + int'(TO) + 2, 2'b01, '0, 1'b1);
        tick();
        m_valid = '0;
        for (int k = 0; k <= int'(TO); k++) begin
            @(negedge clk);
            check("to_s_valid_hi", s_valid, 1'b1);
            tick();
        end
        @(negedge clk);
        check("to_s_valid_lo", s_valid, 1'b0);
        tick();
        // Late downstream pulses in IDLE must be ignored
        s_ready  = 1'b1;
        s_rvalid = 1'b1;
        s_rdata  = {16{8'hEE}};
        tick();
        s_ready  = 1'b0;
        s_rvalid = 1'b0;
        s_rdata  = '0;
        @(negedge clk);
        check("late_s_valid", s_valid, 1'b0);
        tick();

        // Timeout in WAIT
        m_valid = '0;
        drive_req(1, 1'b0, 32'h8000_0030, '0, '0);
        expect_accept("tow_grant", 2'b10, t);
        push(t + int'(TO) + 2, 2'b10, '0, 1'b1);
        tick();
        m_valid = '0;
        s_ready = 1'b1;
        tick();
        s_ready = 1'b0;
        for (int k = 0; k < int'(TO); k++) begin
            @(negedge clk);
            check("tow_s_valid_lo", s_valid, 1'b0);
            tick();
        end
        tick();

        // s_ready on the timeout cycle beats the timeout
        d = {4{32'h5A5A_0042}};
        m_valid = '0;
        drive_req(0, 1'b0, 32'h8000_0040, '0, '0);
        expect_accept("prio_grant", 2'b01, t);
        push(t + int'(TO) + 3, 2'b01, d, 1'b0);
        tick();
        m_valid = '0;
        repeat (TO) tick();
        s_ready = 1'b1;
        @(negedge clk);
        check("prio_s_valid", s_valid, 1'b1);
        tick();
        s_ready  = 1'b0;
        s_rvalid = 1'b1;
        s_rdata  = d;
        tick();
        s_rvalid = 1'b0;
        s_rdata  = '0;
        tick();

        // Write from requester 1
        m_valid = '0;
        drive_req(1, 1'b1, 32'h8000_0080, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 16'h00F0);
        expect_accept("wr_grant", 2'b10, t);
        push(t + 3, 2'b10, {4{32'h0000_BEEF}}, 1'b0);
        tick();
        m_valid = '0;
        s_ready = 1'b1;
        @(negedge clk);
        check("wr_s_valid", s_valid, 1'b1);
        check("wr_s_we", s_we, 1'b1);
        check("wr_s_addr", s_addr, 32'h8000_0080);
        check("wr_s_wmask", s_wmask, 16'h00F0);
        check("wr_s_wdata", s_wdata, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        tick();
        s_ready  = 1'b0;
        s_rvalid = 1'b1;
        s_rdata  = {4{32'h0000_BEEF}};
        tick();
        s_rvalid = 1'b0;
        s_rdata  = '0;
        tick();

        // Reset while in WAIT: no response, then requester 0 wins the first tie
        m_valid = '0;
        drive_req(0, 1'b0, 32'h8000_0050, '0, '0);
        expect_accept("pre_rst_grant", 2'b01, t);
        tick();
        m_valid = '0;
        s_ready = 1'b1;
        tick();
        s_ready = 1'b0;
        rst = 1'b0;
        drive_req(0, 1'b0, 32'h8000_0050, '0, '0);
        drive_req(1, 1'b0, 32'h8000_0060, '0, '0);
        tick();
        s_rvalid = 1'b1;
        s_rdata  = {16{8'h77}};
        @(negedge clk);
        check("midrst_s_valid", s_valid, 1'b0);
        check("midrst_m_ready", m_ready, 2'b00);
        check("midrst_m_rvalid", m_rvalid, 2'b00);
        check("midrst_m_rdata", m_rdata, '0);
        tick();
        s_rvalid = 1'b0;
        s_rdata  = '0;
        rst = 1'b1;
        d = {4{32'h600D_0001}};
        expect_accept("post_rst_tie", 2'b01, t2);
        push(t2 + 3, 2'b01, d, 1'b0);
        serve(32'h8000_0050, d, 2'b00);
        tick();

        repeat (3) tick();
        check("pending_rsp", 128'(sb_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
